// File: rtl/digital_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digital_pll_pkg
// Brief    : Shared constants, types and helpers for the digital PLL slice
//            (controller, trim weighting and DCO model).
// Revision : 1.0 - initial release
// ============================================================================
package digital_pll_pkg;

    // Width of the controller -> oscillator trim bus.
    localparam int TRIM_W   = 26;
    // Bits needed to hold a count of 0..TRIM_W set trim bits.
    localparam int WEIGHT_W = $clog2(TRIM_W + 1);

    // Oscillator operating mode; selected directly by the enable input.
    typedef enum logic {
        DCO_IDLE = 1'b0,
        DCO_RUN  = 1'b1
    } dco_state_e;

    // Number of set bits in a trim word; bit position carries no weight.
    function automatic logic [WEIGHT_W-1:0] popcount(input logic [TRIM_W-1:0] v);
        logic [WEIGHT_W-1:0] n;
        n = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            n = n + WEIGHT_W'(v[i]);
        end
        return n;
    endfunction

endpackage : digital_pll_pkg
`default_nettype wire

// File: rtl/pll_trim_weight.sv
`default_nettype none
// ============================================================================
// Module   : pll_trim_weight
// Brief    : Combinational trim weighting - counts the set bits of the
//            registered trim word (0..TRIM_W).
// Revision : 1.0 - initial release
// ============================================================================
module pll_trim_weight
    import digital_pll_pkg::*;
#(
    parameter int TRIM_W   = digital_pll_pkg::TRIM_W,
    parameter int WEIGHT_W = $clog2(TRIM_W + 1)
) (
    input  logic [TRIM_W-1:0]   i_trim_q,
    output logic [WEIGHT_W-1:0] o_weight
);

    if (TRIM_W == digital_pll_pkg::TRIM_W) begin : g_pkg_popcount
        // Default bus width: reuse the shared helper.
        assign o_weight = WEIGHT_W'(popcount(i_trim_q));
    end else begin : g_generic_popcount
        logic [WEIGHT_W-1:0] w_count;

        // Non-default bus width: count set bits with a local loop.
        always_comb begin
            w_count = '0;
            for (int i = 0; i < TRIM_W; i++) begin
                w_count = w_count + WEIGHT_W'(i_trim_q[i]);
            end
        end

        assign o_weight = w_count;
    end

endmodule : pll_trim_weight
`default_nettype wire

// File: rtl/digital_pll_dco_model.sv
`default_nettype none
// ============================================================================
// Module   : digital_pll_dco_model
// Brief    : Clocked model of the trim-controlled ring oscillator. Each set
//            trim bit lengthens the osc half-period by STEP clock cycles on
//            top of BASE_HALF; a running half-period is never altered.
// Revision : 1.0 - initial release
// ============================================================================
module digital_pll_dco_model
    import digital_pll_pkg::*;
#(
    parameter int TRIM_W    = digital_pll_pkg::TRIM_W,
    parameter int BASE_HALF = 4,
    parameter int STEP      = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [TRIM_W-1:0] trim,
    output logic              osc,
    output logic              osc_edge,
    output logic [CNT_W-1:0]  half_len
);

    localparam int c_WEIGHT_W = $clog2(TRIM_W + 1);

    logic [TRIM_W-1:0]     r_trim_q;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_half_len;
    logic                  r_osc;
    logic                  r_osc_edge;
    logic [c_WEIGHT_W-1:0] w_weight;
    logic [CNT_W-1:0]      w_target;
    dco_state_e            w_state;

    pll_trim_weight #(
        .TRIM_W   (TRIM_W),
        .WEIGHT_W (c_WEIGHT_W)
    ) u_trim_weight (
        .i_trim_q (r_trim_q),
        .o_weight (w_weight)
    );

    // Half-period for the next half; CNT_W is sized so this never truncates.
    assign w_target = CNT_W'(BASE_HALF) + CNT_W'(STEP) * CNT_W'(w_weight);

    // No state register: enable alone chooses between idle and running.
    assign w_state = enable ? DCO_RUN : DCO_IDLE;

    // Trim capture, half-period counter and osc toggle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_trim_q   <= '0;
            r_cnt      <= '0;
            r_half_len <= CNT_W'(BASE_HALF);
            r_osc      <= 1'b0;
            r_osc_edge <= 1'b0;
        end else begin
            r_trim_q <= trim;
            case (w_state)
                DCO_RUN: begin
                    if (r_cnt == r_half_len - CNT_W'(1)) begin
                        // End of half: toggle and latch the length of the next half.
                        r_osc      <= ~r_osc;
                        r_osc_edge <= 1'b1;
                        r_cnt      <= '0;
                        r_half_len <= w_target;
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
                        r_osc_edge <= 1'b0;
                    end
                end
                default: begin
                    // Idle: hold osc low and let half_len follow the trim.
                    r_osc      <= 1'b0;
                    r_osc_edge <= 1'b0;
                    r_cnt      <= '0;
                    r_half_len <= w_target;
                end
            endcase
        end
    end

    assign osc      = r_osc;
    assign osc_edge = r_osc_edge;
    assign half_len = r_half_len;

endmodule : digital_pll_dco_model
`default_nettype wire

// File: tb/tb_digital_pll_dco_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_digital_pll_dco_model
// Brief    : Directed self-checking bench for digital_pll_dco_model
//            (defaults: TRIM_W=26, BASE_HALF=4, STEP=1, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digital_pll_dco_model;

    localparam int TRIM_W = 26;
    localparam int CNT_W  = 8;
    localparam int BUDGET = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [TRIM_W-1:0] trim = '0;
    logic              osc;
    logic              osc_edge;
    logic [CNT_W-1:0]  half_len;

    int errors = 0;
    int checks = 0;

    digital_pll_dco_model #(
        .TRIM_W    (TRIM_W),
        .BASE_HALF (4),
        .STEP      (1),
        .CNT_W     (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .trim     (trim),
        .osc      (osc),
        .osc_edge (osc_edge),
        .half_len (half_len)
    );

    always #5 clock = ~clock;

    // One clock cycle; outputs are stable 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cycles until the next osc_edge pulse, or -1 if it never comes.
    task automatic wait_edge(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!osc_edge && n < BUDGET);
        if (!osc_edge) n = -1;
    endtask

    // Go idle with a new trim and let half_len settle (capture + load).
    task automatic load_idle(input logic [TRIM_W-1:0] t);
        enable = 1'b0;
        trim   = t;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        trim   = {TRIM_W{1'b1}};
        tick();
        tick();
        checks++;
        if (osc !== 1'b0) begin
            errors++;
            $display("FAIL reset_osc: got %b expected 0", osc);
        end
        checks++;
        if (osc_edge !== 1'b0) begin
            errors++;
            $display("FAIL reset_osc_edge: got %b expected 0", osc_edge);
        end
        checks++;
        if (half_len !== 8'd4) begin
            errors++;
            $display("FAIL reset_half_len: got %0d expected 4", half_len);
        end
        reset  = 1'b0;
        enable = 1'b0;
        trim   = '0;
        tick();
        checks++;
        if (half_len !== 8'd4) begin
            errors++;
            $display("FAIL reset_release_half_len: got %0d expected 4", half_len);
        end
    endtask

    task automatic test_basic_run();
        int n;
        load_idle('0);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (osc !== 1'b0 || osc_edge !== 1'b0) begin
                errors++;
                $display("FAIL basic_pre_edge cycle %0d: got osc=%b edge=%b expected 0/0", i, osc, osc_edge);
            end
        end
        tick();
        checks++;
        if (osc !== 1'b1 || osc_edge !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_rise: got osc=%b edge=%b expected 1/1", osc, osc_edge);
        end
        tick();
        checks++;
        if (osc_edge !== 1'b0 || osc !== 1'b1) begin
            errors++;
            $display("FAIL basic_edge_pulse_width: got osc=%b edge=%b expected 1/0", osc, osc_edge);
        end
        wait_edge(n);
        checks++;
        if (n != 3 || osc !== 1'b0) begin
            errors++;
            $display("FAIL basic_fall: got %0d cycles osc=%b expected 3 cycles osc=0", n, osc);
        end
        wait_edge(n);
        checks++;
        if (n != 4 || osc !== 1'b1) begin
            errors++;
            $display("FAIL basic_second_rise: got %0d cycles osc=%b expected 4 cycles osc=1", n, osc);
        end
    endtask

    // Idle-load a trim, check half_len, then time the first two halves.
    task automatic test_trim_weight(input logic [TRIM_W-1:0] t, input int exp_h, input string name);
        int n1;
        int n2;
        load_idle(t);
        checks++;
        if (half_len !== CNT_W'(exp_h)) begin
            errors++;
            $display("FAIL %s_half_len: got %0d expected %0d", name, half_len, exp_h);
        end
        enable = 1'b1;
        wait_edge(n1);
        wait_edge(n2);
        checks++;
        if (n1 != exp_h || n2 != exp_h || osc !== 1'b0) begin
            errors++;
            $display("FAIL %s_period: got halves %0d,%0d osc=%b expected %0d,%0d osc=0",
                     name, n1, n2, osc, exp_h, exp_h);
        end
    endtask

    task automatic test_mid_half_trim();
        int n;
        load_idle('0);
        enable = 1'b1;
        wait_edge(n);
        tick();
        tick();
        trim = 26'h000000F;
        wait_edge(n);
        checks++;
        if (n != 2 || half_len !== 8'd8) begin
            errors++;
            $display("FAIL mid_half_keep: got %0d remaining half_len=%0d expected 2 remaining half_len=8", n, half_len);
        end
        wait_edge(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL mid_half_next: got %0d expected 8", n);
        end
    endtask

    task automatic test_toggle_cycle_trim();
        int n;
        load_idle('0);
        enable = 1'b1;
        wait_edge(n);
        tick();
        tick();
        tick();
        trim = 26'h000000F;
        tick();
        checks++;
        if (osc_edge !== 1'b1 || half_len !== 8'd4) begin
            errors++;
            $display("FAIL toggle_trim_old: got edge=%b half_len=%0d expected 1/4", osc_edge, half_len);
        end
        wait_edge(n);
        checks++;
        if (n != 4 || half_len !== 8'd8) begin
            errors++;
            $display("FAIL toggle_trim_new: got %0d half_len=%0d expected 4/8", n, half_len);
        end
    endtask

    task automatic test_interrupt();
        int n;
        load_idle(26'h000000F);
        enable = 1'b1;
        wait_edge(n);
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if (osc !== 1'b0 || osc_edge !== 1'b0) begin
            errors++;
            $display("FAIL disable_mid_half: got osc=%b edge=%b expected 0/0", osc, osc_edge);
        end
        tick();
        enable = 1'b1;
        wait_edge(n);
        checks++;
        if (n != 8 || osc !== 1'b1) begin
            errors++;
            $display("FAIL reenable_rise: got %0d cycles osc=%b expected 8 cycles osc=1", n, osc);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (osc !== 1'b0 || half_len !== 8'd4 || osc_edge !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got osc=%b half_len=%0d edge=%b expected 0/4/0", osc, half_len, osc_edge);
        end
        reset  = 1'b0;
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_trim_weight(26'h3FFFFFF, 30, "full_trim");
        test_trim_weight(26'h00000FF, 12, "therm8");
        test_trim_weight(26'h2000001, 6, "nontherm");
        test_mid_half_trim();
        test_toggle_cycle_trim();
        test_interrupt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_digital_pll_dco_model
`default_nettype wire
